// File: rtl/pipemdu_if.sv
// Bundle of signals between the EX stage and the multiply/divide sequencer.
// The master side is the pipeline; the slave side is the sequencer.
interface pipemdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic             whi;
    logic             wlo;
    logic             kill;
    logic             stall;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, ea, eb, whi, wlo, kill,
        input  stall, done, dz, hi, lo
    );

    modport slave (
        input  start, op, ea, eb, whi, wlo, kill,
        output stall, done, dz, hi, lo
    );
endinterface

// File: rtl/pipemdu.sv
// Iterative multiply/divide sequencer beside the EX-stage ALU; owns HI/LO.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, WIDTH iterations
// each, with sign correction applied once at the end on magnitudes.
//
//  state  | meaning
//  IDLE   | waiting for start; MTHI/MTLO writes allowed
//  CALC   | one iteration per clock, WIDTH clocks total
//  FIX    | sign correction, HI/LO written at the exit edge
//  DONE   | one-cycle release window; start ignored, MTHI/MTLO allowed
module pipemdu #(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     resetn,
    pipemdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;       // product, or {remainder, quotient}
    logic [WIDTH-1:0]   mreg;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   ea_raw;    // dividend as issued, for divide-by-zero HI
    logic               is_div;
    logic               sa;        // signed op and ea negative
    logic               sb;        // signed op and eb negative
    logic               bzero;
    logic               done_r;
    logic               dz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               sgn_op;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes at accept time; unsigned ops pass straight through.
    always_comb begin
        sgn_op = ~bus.op[0];
        mag_a  = (sgn_op && bus.ea[WIDTH-1]) ? -bus.ea : bus.ea;
        mag_b  = (sgn_op && bus.eb[WIDTH-1]) ? -bus.eb : bus.eb;
    end

    // Next iteration of both datapaths plus the final sign-corrected results.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mreg} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};

        // Trial subtract is one bit wider so the borrow lands in the top bit.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, mreg};
        if (!div_trial[WIDTH])
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

        prod_fix = (sa ^ sb) ? -acc : acc;
        quo_fix  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Sequencer FSM with datapath registers and HI/LO ownership.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= S_IDLE;
            count  <= '0;
            acc    <= '0;
            mreg   <= '0;
            ea_raw <= '0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            bzero  <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            if (bus.kill) begin
                // A flushed instruction never writes HI/LO.
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            is_div <= bus.op[1];
                            sa     <= sgn_op & bus.ea[WIDTH-1];
                            sb     <= sgn_op & bus.eb[WIDTH-1];
                            bzero  <= (bus.eb == '0);
                            ea_raw <= bus.ea;
                            count  <= '0;
                            if (bus.op[1]) begin
                                acc  <= {{WIDTH{1'b0}}, mag_a};
                                mreg <= mag_b;
                            end else begin
                                acc  <= {{WIDTH{1'b0}}, mag_b};
                                mreg <= mag_a;
                            end
                            state <= S_CALC;
                        end else begin
                            if (bus.whi) hi_r <= bus.ea;
                            if (bus.wlo) lo_r <= bus.ea;
                        end
                    end
                    S_CALC: begin
                        acc   <= is_div ? div_next : mul_next;
                        count <= count + CW'(1);
                        if (count == CW'(WIDTH - 1))
                            state <= S_FIX;
                    end
                    S_FIX: begin
                        if (is_div && bzero) begin
                            hi_r <= ea_raw;
                            lo_r <= '1;
                            dz_r <= 1'b1;
                        end else if (is_div) begin
                            hi_r <= rem_fix;
                            lo_r <= quo_fix;
                        end else begin
                            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_r <= prod_fix[WIDTH-1:0];
                        end
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end
                    S_DONE: begin
                        // start here is still the finished instruction; ignore it.
                        if (bus.whi) hi_r <= bus.ea;
                        if (bus.wlo) lo_r <= bus.ea;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.stall = ~bus.kill & (((state == S_IDLE) & bus.start) |
                                    (state == S_CALC) | (state == S_FIX));
    assign bus.done  = done_r;
    assign bus.dz    = dz_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
endmodule

// File: tb/tb_pipemdu.sv
// Bench for pipemdu: directed cases plus random mul/div against an
// arithmetic reference model.
module tb_pipemdu;
    localparam int W = 32;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int errors = 0;
    int dz_bad = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    pipemdu_if #(.WIDTH(W)) bus();
    pipemdu #(.WIDTH(W)) dut (.clock(clock), .resetn(resetn), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_mdu(input logic [1:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] rh,
                                    output logic [W-1:0] rl, output logic rz);
        longint pa, pb;
        logic [63:0] p;
        int qa, qb;
        rz = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
                p  = pa * pb;
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                p  = {32'b0, a} * {32'b0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (b == 0) begin
                    rh = a;
                    rl = '1;
                    rz = 1'b1;
                end else if (o == 2'b11) begin
                    rl = a / b;
                    rh = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000;
                    rh = '0;
                end else begin
                    qa = $signed(a);
                    qb = $signed(b);
                    rl = qa / qb;
                    rh = qa % qb;
                end
            end
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns #1 into the done cycle
    // with start still high, as the pipeline would hold it.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit poke);
        int cyc, stalls;
        bit got;
        logic [W-1:0] rh, rl;
        logic rz;
        ref_mdu(o, a, b, rh, rl, rz);
        bus.start = 1'b1;
        bus.op = o;
        bus.ea = a;
        bus.eb = b;
        #1;
        chk("accept_stall", bus.stall, 1);
        chk("accept_done", bus.done, 0);
        cyc = 1;
        stalls = bus.stall ? 1 : 0;
        got = 0;
        while (!got && cyc < 60) begin
            @(negedge clock);
            if (poke && cyc == 5) begin
                bus.whi = 1'b1;
                bus.wlo = 1'b1;
                bus.ea = ~a;
            end else if (poke && cyc == 6) begin
                bus.whi = 1'b0;
                bus.wlo = 1'b0;
                bus.ea = a;
            end
            #1;
            cyc++;
            if (bus.done) got = 1;
            else begin
                if (bus.stall) stalls++;
                if (bus.dz) dz_bad++;
            end
        end
        chk("done_seen", got, 1);
        chk("stall_len", stalls, 34);
        chk("done_cycle", cyc, 35);
        chk("done_stall", bus.stall, 0);
        chk("hi", bus.hi, rh);
        chk("lo", bus.lo, rl);
        chk("dz", bus.dz, rz);
        exp_hi = rh;
        exp_lo = rl;
    endtask

    // Drop start after a done window and confirm the pulse ended cleanly.
    task automatic release_idle();
        @(negedge clock);
        bus.start = 1'b0;
        #1;
        chk("post_done", bus.done, 0);
        chk("post_stall", bus.stall, 0);
        chk("post_dz", bus.dz, 0);
    endtask

    logic [W-1:0] ra, rb;
    int done_seen;

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.ea = '0;
        bus.eb = '0;
        bus.whi = 1'b0;
        bus.wlo = 1'b0;
        bus.kill = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_stall", bus.stall, 0);

        @(negedge clock);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", bus.lo, 32'h0000_0001);
        release_idle();

        @(negedge clock);
        do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
        chk("mult_neg_lo", bus.lo, 32'hFFFF_FFF1);
        @(negedge clock);
        do_op(2'b00, 32'd7, 32'd6, 0);
        chk("mult_b2b_lo", bus.lo, 32'd42);
        release_idle();

        @(negedge clock);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        @(negedge clock);
        do_op(2'b11, 32'd100, 32'd7, 1);
        chk("divu_lo", bus.lo, 32'd14);
        @(negedge clock);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_lo", bus.lo, 32'h8000_0000);
        release_idle();

        @(negedge clock);
        do_op(2'b11, 32'd100, 32'd0, 0);
        chk("divz_hi", bus.hi, 32'h64);
        release_idle();

        // kill during the tenth CALC cycle
        @(negedge clock);
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.ea = 32'd3;
        bus.eb = 32'd4;
        repeat (10) @(negedge clock);
        bus.kill = 1'b1;
        #1;
        chk("kill_stall", bus.stall, 0);
        @(negedge clock);
        bus.kill = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("kill_idle_stall", bus.stall, 0);
        chk("kill_hi", bus.hi, exp_hi);
        chk("kill_lo", bus.lo, exp_lo);
        done_seen = 0;
        repeat (40) begin
            @(negedge clock);
            #1;
            if (bus.done) done_seen++;
        end
        chk("kill_no_done", done_seen, 0);
        chk("kill_hi_late", bus.hi, exp_hi);

        @(negedge clock);
        bus.whi = 1'b1;
        bus.ea = 32'h1234_5678;
        @(negedge clock);
        bus.whi = 1'b0;
        bus.wlo = 1'b1;
        bus.ea = 32'h9ABC_DEF0;
        #1;
        chk("mthi", bus.hi, 32'h1234_5678);
        @(negedge clock);
        bus.wlo = 1'b0;
        #1;
        chk("mtlo", bus.lo, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", bus.hi, 32'h1234_5678);

        for (int i = 0; i < 16; i++) begin
            ra = pick();
            rb = pick();
            @(negedge clock);
            do_op(2'($urandom_range(0, 3)), ra, rb, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) release_idle();
        end
        release_idle();

        // reset during CALC
        @(negedge clock);
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.ea = 32'd9;
        bus.eb = 32'd9;
        repeat (6) @(negedge clock);
        resetn = 1'b0;
        bus.start = 1'b0;
        @(negedge clock);
        #1;
        chk("rstcalc_hi", bus.hi, 0);
        chk("rstcalc_lo", bus.lo, 0);
        chk("rstcalc_stall", bus.stall, 0);
        chk("rstcalc_done", bus.done, 0);
        resetn = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clock);
            #1;
            if (bus.done) done_seen++;
        end
        chk("rstcalc_no_done", done_seen, 0);

        chk("dz_window", dz_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
